// File: rtl/vga_mode_pkg.sv
// Shared types and constants for the VGA mode sequencer.
package vga_mode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        WAIT_VS,
        SWITCH,
        SETTLE
    } state_e;

    localparam logic [1:0] MODE_640X480 = 2'b00;
    localparam logic [1:0] MODE_800X600 = 2'b01;
    localparam logic [1:0] MODE_640X350 = 2'b10;
    localparam logic [1:0] MODE_768X576 = 2'b11;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/vga_pix_ce_gen.sv
// Pixel clock-enable divider: one pulse every freq_factor cycles, restartable by clear.
module vga_pix_ce_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic [2:0] freq_factor_i,
    output logic       pix_ce_o
);

    logic [2:0] cnt_q, cnt_d;
    logic       pix_ce_q;

    // Wrap also covers a shrinking ratio that leaves the counter beyond the new end.
    always_comb begin
        cnt_d = cnt_q + 3'd1;
        if (clear_i || (freq_factor_i <= 3'd1) || (cnt_q >= freq_factor_i - 3'd1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pix_ce_q <= (cnt_d == '0);
        end
    end

    assign pix_ce_o = pix_ce_q;

endmodule

// File: rtl/vga_mode_sequencer.sv
// Debounces mode switches, applies a new resolution on a vsync boundary and blanks
// while the monitor re-locks. Optional synchronised mode_lock input: VGA_MODE_LOCK_EN.
module vga_mode_sequencer
    import vga_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SETTLE_FRAMES   = 4,
    parameter int unsigned VSYNC_TIMEOUT   = 2000000,
    parameter logic [1:0]  RESET_MODE      = MODE_640X480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode_req,
    input  logic       v_sync,
`ifdef VGA_MODE_LOCK_EN
    input  logic       mode_lock,
`endif
    input  logic [2:0] freq_factor,
    output logic [1:0] resolution_select,
    output logic       blank,
    output logic       pix_ce,
    output logic       busy,
    output logic       mode_changed
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > VSYNC_TIMEOUT) ? DEBOUNCE_CYCLES
                                                                        : VSYNC_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned FRM_W   = $clog2(SETTLE_FRAMES) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(VSYNC_TIMEOUT - 1);
    localparam logic [FRM_W-1:0] FRM_DONE = FRM_W'(SETTLE_FRAMES);

    logic [1:0] mode_sync_q [SYNC_STAGES];
    logic       vs_sync_q   [SYNC_STAGES];
    logic       vs_prev_q;
    logic [1:0] mode_prev_q;
    logic [1:0] mode_s;
    logic       vs_fall;
    logic       lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                mode_sync_q[i] <= RESET_MODE;
                vs_sync_q[i]   <= 1'b1;
            end
            vs_prev_q   <= 1'b1;
            mode_prev_q <= RESET_MODE;
        end else begin
            mode_sync_q[0] <= mode_req;
            vs_sync_q[0]   <= v_sync;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                mode_sync_q[i] <= mode_sync_q[i-1];
                vs_sync_q[i]   <= vs_sync_q[i-1];
            end
            vs_prev_q   <= vs_sync_q[SYNC_STAGES-1];
            mode_prev_q <= mode_s;
        end
    end

    assign mode_s  = mode_sync_q[SYNC_STAGES-1];
    assign vs_fall = vs_prev_q & ~vs_sync_q[SYNC_STAGES-1];

`ifdef VGA_MODE_LOCK_EN
    logic [SYNC_STAGES-1:0] lock_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], mode_lock};
        end
    end

    assign lock_s = lock_sync_q[SYNC_STAGES-1];
`else
    assign lock_s = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FRM_W-1:0] frames_q, frames_d;
    logic [1:0]       pending_q, pending_d;
    logic [1:0]       res_q, res_d;
    logic             blank_q, blank_d;
    logic             changed_q, changed_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SETTLE;
            cnt_q     <= '0;
            frames_q  <= '0;
            pending_q <= RESET_MODE;
            res_q     <= RESET_MODE;
            blank_q   <= 1'b1;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frames_q  <= frames_d;
            pending_q <= pending_d;
            res_q     <= res_d;
            blank_q   <= blank_d;
            changed_q <= changed_d;
        end
    end

    // SWITCH outputs are registered on entry so the new mode, blank and the
    // mode_changed pulse are all visible during the SWITCH cycle itself.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frames_d  = frames_q;
        pending_d = pending_q;
        res_d     = res_q;
        blank_d   = blank_q;
        changed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!lock_s && (mode_s != res_q)) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (lock_s || (mode_s == res_q)) begin
                    state_d = IDLE;
                end else if (mode_s != mode_prev_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    pending_d = mode_s;
                    state_d   = WAIT_VS;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_VS: begin
                if (vs_fall || (cnt_q == TO_LAST)) begin
                    state_d   = SWITCH;
                    res_d     = pending_q;
                    blank_d   = 1'b1;
                    changed_d = 1'b1;
                    frames_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SWITCH: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (vs_fall) begin
                    frames_d = frames_q + FRM_W'(1);
                    if (frames_q + FRM_W'(1) == FRM_DONE) begin
                        blank_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    vga_pix_ce_gen u_pix_ce_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (state_q == SWITCH),
        .freq_factor_i (freq_factor),
        .pix_ce_o      (pix_ce)
    );

    assign resolution_select = res_q;
    assign blank             = blank_q;
    assign busy              = (state_q != IDLE);
    assign mode_changed      = changed_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench: directed scenarios plus randomized switching against a timestamp model.
module tb_vga_mode_sequencer;

    localparam int DEB       = 8;
    localparam int SF        = 2;
    localparam int TO        = 100;
    localparam int VS_PERIOD = 50;
    localparam int VS_LOW    = 4;

    localparam int P_IDLE   = 0;
    localparam int P_DEB    = 1;
    localparam int P_WAIT   = 2;
    localparam int P_SW     = 3;
    localparam int P_SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode_req = 2'b00;
    logic       v_sync = 1'b1;
    logic [2:0] freq_factor = 3'd4;
    logic       lock_drv = 1'b0;
    logic [1:0] resolution_select;
    logic       blank, pix_ce, busy, mode_changed;

    always #5 clk = ~clk;

    vga_mode_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .SETTLE_FRAMES   (SF),
        .VSYNC_TIMEOUT   (TO),
        .RESET_MODE      (2'b00)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mode_req          (mode_req),
        .v_sync            (v_sync),
`ifdef VGA_MODE_LOCK_EN
        .mode_lock         (lock_drv),
`endif
        .freq_factor       (freq_factor),
        .resolution_select (resolution_select),
        .blank             (blank),
        .pix_ce            (pix_ce),
        .busy              (busy),
        .mode_changed      (mode_changed)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: phases with absolute edge timestamps, raw input history queues.
    int         ph, dstart, wstart, frames, pos, edge_n;
    logic [1:0] m_res, m_pend;
    logic       m_blank, m_chg, m_pix;
    logic [1:0] hm[$];
    logic       hv[$];
    logic       hl[$];

    task automatic model_reset();
        ph = P_SETTLE; frames = 0; pos = 0; edge_n = 0; dstart = 0; wstart = 0;
        m_res = 2'b00; m_pend = 2'b00; m_blank = 1'b1; m_chg = 1'b0; m_pix = 1'b0;
        hm = '{2'b00, 2'b00, 2'b00};
        hv = '{1'b1, 1'b1, 1'b1};
        hl = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step();
        logic [1:0] ms, msp;
        logic       fall, lk;
        int         ff, k, prev_ph;
        hm.push_back(mode_req); hv.push_back(v_sync); hl.push_back(lock_drv);
        if (hm.size() > 4) begin
            void'(hm.pop_front()); void'(hv.pop_front()); void'(hl.pop_front());
        end
        // Edge k acts on raw inputs sampled two edges earlier; falls one more back.
        ms = hm[1]; msp = hm[0]; fall = hv[0] && !hv[1]; lk = hl[1];
        edge_n++; k = edge_n;
        ff = int'(freq_factor);
        prev_ph = ph;
        if (prev_ph == P_SW || ff <= 1 || pos + 1 >= ff) pos = 0;
        else pos = pos + 1;
        m_pix = (pos == 0);
        m_chg = 1'b0;
        if (prev_ph == P_IDLE) begin
            if (!lk && ms != m_res) begin ph = P_DEB; dstart = k; end
        end else if (prev_ph == P_DEB) begin
            if (lk || ms == m_res) ph = P_IDLE;
            else if (ms != msp) dstart = k;
            else if (k - dstart == DEB) begin m_pend = ms; ph = P_WAIT; wstart = k; end
        end else if (prev_ph == P_WAIT) begin
            if (fall || k - wstart == TO) begin
                ph = P_SW; m_res = m_pend; m_blank = 1'b1; m_chg = 1'b1; frames = 0;
            end
        end else if (prev_ph == P_SW) begin
            ph = P_SETTLE;
        end else begin
            if (fall) begin
                frames++;
                if (frames == SF) begin m_blank = 1'b0; ph = P_IDLE; end
            end
        end
    endtask

    int tcount = 0;
    logic vs_hold = 1'b0;
    int mc_seen = 0;

    task automatic check_outputs();
        check("res",   32'(resolution_select), 32'(m_res));
        check("blank", 32'(blank),             32'(m_blank));
        check("busy",  32'(busy),              32'(ph != P_IDLE));
        check("mchg",  32'(mode_changed),      32'(m_chg));
        check("pixce", 32'(pix_ce),            32'(m_pix));
        if (mode_changed === 1'b1) mc_seen++;
    endtask

    // Called at a negedge: drive inputs for the next posedge, advance model, check after it.
    task automatic tick();
        v_sync = vs_hold ? 1'b1 : ((tcount % VS_PERIOD) < VS_LOW ? 1'b0 : 1'b1);
        tcount++;
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int t_busy, t_mc, hold_left;
    logic reached;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        check("rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;

        // 1: power-up settle
        run(160);
        check("s1_blank", 32'(blank), 32'd0);
        check("s1_busy",  32'(busy),  32'd0);
        check("s1_res",   32'(resolution_select), 32'd0);

        // 2: steady request to 01
        mode_req = 2'b01;
        run(220);
        check("s2_res", 32'(resolution_select), 32'd1);
        mode_req = 2'b00;
        run(250);

        // 3: chattering switch never accepted
        mc_seen = 0;
        for (int i = 0; i < 8; i++) begin
            mode_req = (i % 2 == 0) ? 2'b01 : 2'b00;
            run(5);
        end
        mode_req = 2'b00;
        run(60);
        check("s3_nochg", 32'(mc_seen), 32'd0);
        check("s3_res",   32'(resolution_select), 32'd0);

        // 4: vsync held high, switch on timeout
        vs_hold = 1'b1;
        mode_req = 2'b10;
        t_busy = -1; t_mc = -1;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (busy === 1'b1 && t_busy < 0) t_busy = i;
            if (mode_changed === 1'b1 && t_mc < 0) t_mc = i;
        end
        check("s4_lat", 32'(t_mc - t_busy), 32'(DEB + TO));
        check("s4_res", 32'(resolution_select), 32'd2);

        // 5: request made during SETTLE waits for IDLE
        vs_hold = 1'b0;
        mode_req = 2'b11;
        run(30);
        check("s5_held", 32'(resolution_select), 32'd2);
        run(320);
        check("s5_res", 32'(resolution_select), 32'd3);

        // 6: async reset while in WAIT_VS
        vs_hold = 1'b1;
        mode_req = 2'b01;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            tick();
            if (ph == P_WAIT) reached = 1'b1;
        end
        check("s6_wait", 32'(reached), 32'd1);
        run(20);
        rst_n = 1'b0;
        #1;
        check("s6_res",   32'(resolution_select), 32'd0);
        check("s6_blank", 32'(blank),             32'd1);
        check("s6_mchg",  32'(mode_changed),      32'd0);
        model_reset();
        run(3);
        rst_n = 1'b1;
        vs_hold = 1'b0;
        mode_req = 2'b00;
        run(160);
        check("s6_after", 32'(resolution_select), 32'd0);

        // Randomized switching, vsync dropouts and ratio changes
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_left == 0) begin
                mode_req  = 2'($urandom_range(0, 3));
                hold_left = $urandom_range(1, 24);
            end
            hold_left--;
            if ($urandom_range(0, 299) == 0) vs_hold = ~vs_hold;
            if ($urandom_range(0, 199) == 0) freq_factor = 3'($urandom_range(0, 7));
            tick();
        end
        freq_factor = 3'd4;
        vs_hold = 1'b0;

`ifdef VGA_MODE_LOCK_EN
        mode_req = m_res;
        run(400);
        lock_drv = 1'b1;
        run(5);
        mode_req = m_res ^ 2'b01;
        run(60);
        check("lock_idle", 32'(busy), 32'd0);
        check("lock_res",  32'(resolution_select ^ mode_req), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
